dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. Port 0 (CPU load/store) and port 1
// (debug/DMA) share one asynchronous-read data memory. Each access takes
// three cycles: IDLE (arbitrate) -> ACCESS (drive memory) -> RESP (ack).
// Contention is resolved round-robin. Word-misaligned accesses never reach
// memory and complete with err set.
module dmem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;   // port granted most recently
  logic              gnt_q;          // port owning the access in flight
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata0_q, rdata1_q;

  logic              grant_en;
  logic              grant_port;
  logic              misaligned;
  logic [31:0]       resp_data;

  // Arbitration: round-robin when both request, otherwise the lone requester.
  always_comb begin
    grant_en   = (state_q == IDLE) && (req0 || req1);
    grant_port = (req0 && req1) ? ~last_grant_q : req1;
  end

  assign misaligned = (addr_q[1:0] != 2'b00);
  // Writes and misaligned accesses return zero; aligned reads return memory.
  assign resp_data  = (we_q || misaligned) ? 32'h0 : mem_dout;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed three-cycle walk once a request is seen.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req0 || req1) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture on grant and response-data capture at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
    end else begin
      if (grant_en) begin
        last_grant_q <= grant_port;
        gnt_q        <= grant_port;
        we_q         <= grant_port ? we1    : we0;
        addr_q       <= grant_port ? addr1  : addr0;
        wdata_q      <= grant_port ? wdata1 : wdata0;
      end
      if (state_q == ACCESS) begin
        if (gnt_q) rdata1_q <= resp_data;
        else       rdata0_q <= resp_data;
      end
    end
  end

  // Output decode: memory strobes in ACCESS, ack/err in RESP.
  always_comb begin
    mem_addr  = '0;
    mem_din   = 32'h0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    unique case (state_q)
      ACCESS: begin
        mem_addr  = addr_q;
        mem_din   = wdata_q;
        // NOTE: strobes are gated by reset combinationally so a reset raised
        // during ACCESS stops the write from landing on the same edge.
        mem_read  = !we_q && !misaligned && !reset;
        mem_write =  we_q && !misaligned && !reset;
      end
      RESP: begin
        ack0 = !gnt_q;
        ack1 =  gnt_q;
        err0 = !gnt_q && misaligned;
        err1 =  gnt_q && misaligned;
      end
      default: ;
    endcase
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. A transaction-level model predicts, per
// cycle, which access is in its memory cycle or its response cycle and what
// every output must be; a compare process checks all outputs each cycle.
module tb_dmem_arbiter;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       wdata0, wdata1;
  logic              ack0, ack1, err0, err1;
  logic [31:0]       rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din, mem_dout;
  logic              mem_read, mem_write, busy;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT: asynchronous read, write on rising edge.
  logic [31:0] mem [256];
  assign mem_dout = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write === 1'b1) mem[mem_addr[9:2]] <= mem_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // An access granted at edge e owns the memory during cycle e, responds
  // during cycle e+1, and the arbiter is free again from cycle e+2.
  int          cyc = 0;
  int          idle_from = 0;
  bit          valid = 0;
  bit          active = 0;
  int          t_acc, t_resp;
  bit          t_port, t_we;
  logic [31:0] t_addr, t_wdata;
  bit          last = 1;
  logic [31:0] rd [2];
  logic [31:0] shadow [256];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      valid = 1; active = 0; last = 1;
      rd[0] = 32'h0; rd[1] = 32'h0;
      idle_from = cyc;
    end else if (valid) begin
      if (active && t_acc == cyc - 1) begin
        if (t_addr[1:0] != 2'b00 || t_we) rd[t_port] = 32'h0;
        else                              rd[t_port] = shadow[t_addr[9:2]];
        if (t_addr[1:0] == 2'b00 && t_we) shadow[t_addr[9:2]] = t_wdata;
      end
      if (cyc - 1 >= idle_from && (req0 || req1)) begin
        if (req0 && req1) t_port = ~last;
        else              t_port = req1;
        last    = t_port;
        t_we    = t_port ? we1    : we0;
        t_addr  = t_port ? addr1  : addr0;
        t_wdata = t_port ? wdata1 : wdata0;
        active  = 1;
        t_acc   = cyc;
        t_resp  = cyc + 1;
        idle_from = cyc + 2;
      end
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    bit in_acc, in_resp, mis;
    if (valid) begin
      in_acc  = active && (cyc == t_acc);
      in_resp = active && (cyc == t_resp);
      mis     = (t_addr[1:0] != 2'b00);
      check("busy",      {31'h0, busy},      {31'h0, cyc < idle_from});
      check("mem_read",  {31'h0, mem_read},  {31'h0, in_acc && !t_we && !mis && !reset});
      check("mem_write", {31'h0, mem_write}, {31'h0, in_acc &&  t_we && !mis && !reset});
      check("mem_addr",  mem_addr, in_acc ? t_addr  : 32'h0);
      check("mem_din",   mem_din,  in_acc ? t_wdata : 32'h0);
      check("ack0", {31'h0, ack0}, {31'h0, in_resp && !t_port});
      check("ack1", {31'h0, ack1}, {31'h0, in_resp &&  t_port});
      check("err0", {31'h0, err0}, {31'h0, in_resp && !t_port && mis});
      check("err1", {31'h0, err1}, {31'h0, in_resp &&  t_port && mis});
      check("rdata0", rdata0, rd[0]);
      check("rdata1", rdata1, rd[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx]    = v;
    shadow[idx] = v;
  endtask

  // Issue one request, hold it until ack, drop it the following cycle.
  // Reports negedges until ack and the memory strobes seen in ACCESS.
  task automatic do_req(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic a_rd, output logic a_wr,
                        output logic [31:0] a_addr, output logic e);
    logic p_rd, p_wr;
    logic [31:0] p_addr;
    bit got;
    p_rd = 0; p_wr = 0; p_addr = 0;
    lat = 0; a_rd = 0; a_wr = 0; a_addr = 0; e = 0; got = 0;
    if (!port) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wdata; end
    else       begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wdata; end
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if ((!port && ack0 === 1'b1) || (port && ack1 === 1'b1)) begin
        got = 1; lat = i; a_rd = p_rd; a_wr = p_wr; a_addr = p_addr;
        e = port ? err1 : err0;
      end
      p_rd = mem_read; p_wr = mem_write; p_addr = mem_addr;
    end
    if (!got) check("ack_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    if (!port) req0 = 0; else req1 = 0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int          lat;
    logic        a_rd, a_wr, e;
    logic [31:0] a_addr;
    int          ack_cyc[$];
    bit          ack_port[$];

    for (int i = 0; i < 256; i++) set_word(i, 32'h5A5A0000 ^ i);
    set_word(0,  32'h0BADF00D);
    set_word(4,  32'hDEADBEEF);   // 0x10
    set_word(16, 32'h40404040);   // 0x40

    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    tick(2);
    reset = 0;
    @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_rdata0", rdata0, 32'h0);
    tick(1);

    // Single read, port 0.
    do_req(0, 0, 32'h10, 32'h0, lat, a_rd, a_wr, a_addr, e);
    check("rd_latency", lat, 3);
    check("rd_strobe", {31'h0, a_rd}, 32'h1);
    check("rd_addr", a_addr, 32'h10);
    check("rd_data", rdata0, 32'hDEADBEEF);
    check("rd_no_ack1", {31'h0, ack1}, 32'h0);

    // Single write, port 1, then read back on port 0.
    do_req(1, 1, 32'h20, 32'h12345678, lat, a_rd, a_wr, a_addr, e);
    check("wr_latency", lat, 3);
    check("wr_strobe", {31'h0, a_wr}, 32'h1);
    check("wr_addr", a_addr, 32'h20);
    check("wr_rdata1_zero", rdata1, 32'h0);
    do_req(0, 0, 32'h20, 32'h0, lat, a_rd, a_wr, a_addr, e);
    check("readback", rdata0, 32'h12345678);

    // Misaligned write on port 0.
    do_req(0, 1, 32'h3, 32'hAAAA5555, lat, a_rd, a_wr, a_addr, e);
    check("mis_no_write", {31'h0, a_wr}, 32'h0);
    check("mis_err0", {31'h0, e}, 32'h1);
    check("mis_mem_kept", mem[0], 32'h0BADF00D);
    check("mis_rdata0", rdata0, 32'h0);

    // Contention from reset: both ports hold req for four accesses.
    reset = 1; req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    addr0 = 32'h10; addr1 = 32'h20;
    tick(1);
    reset = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack0 === 1'b1) begin ack_cyc.push_back(i); ack_port.push_back(0); end
      if (ack1 === 1'b1) begin ack_cyc.push_back(i); ack_port.push_back(1); end
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    check("rr_count", ack_cyc.size(), 4);
    if (ack_cyc.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("rr_port",  {31'h0, ack_port[k]}, k % 2);
        check("rr_cycle", ack_cyc[k], 3 * (k + 1));
      end
    end
    check("rr_rdata1", rdata1, 32'h12345678);
    tick(1);

    // Misaligned read on port 1 clears its rdata.
    do_req(1, 0, 32'h12, 32'h0, lat, a_rd, a_wr, a_addr, e);
    check("misrd_err1", {31'h0, e}, 32'h1);
    check("misrd_no_read", {31'h0, a_rd}, 32'h0);
    check("misrd_rdata1", rdata1, 32'h0);

    // Port 0 changes addr0 while its read is in ACCESS.
    req0 = 1; we0 = 0; addr0 = 32'h10;
    @(negedge clk);
    tick(1);
    addr0 = 32'h30;
    @(negedge clk);
    check("latched_addr", mem_addr, 32'h10);
    @(negedge clk);
    check("latched_ack0", {31'h0, ack0}, 32'h1);
    check("latched_rdata0", rdata0, 32'hDEADBEEF);
    tick(1);
    req0 = 0;
    tick(1);

    // Reset raised during ACCESS of a write to 0x40.
    req0 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'hCAFEF00D;
    tick(1);
    reset = 1;
    @(negedge clk);
    check("rst_acc_no_write", {31'h0, mem_write}, 32'h0);
    tick(1);
    reset = 0; req0 = 0; we0 = 0;
    @(negedge clk);
    check("rst_acc_busy", {31'h0, busy}, 32'h0);
    check("rst_acc_no_ack", {31'h0, ack0}, 32'h0);
    tick(3);
    check("rst_acc_mem_kept", mem[16], 32'h40404040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
